// File: rtl/act_writeback_if.sv
// rtl/act_writeback_if.sv - job, activation-stream and unified-buffer write signals of act_writeback
interface act_writeback_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 10
);
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [CNT_W-1:0]         num_vals;
    logic [4:0]               shift;
    logic                     valid_in;
    logic signed [31:0]       data_in;
    logic                     ub_wr_en;
    logic [ADDR_W-1:0]        ub_wr_addr;
    logic [31:0]              ub_wr_data;
    logic                     busy;
    logic                     done;

    modport master (
        output start, base_addr, num_vals, shift, valid_in, data_in,
        input  ub_wr_en, ub_wr_addr, ub_wr_data, busy, done
    );

    modport slave (
        input  start, base_addr, num_vals, shift, valid_in, data_in,
        output ub_wr_en, ub_wr_addr, ub_wr_data, busy, done
    );
endinterface

// File: rtl/act_writeback.sv
// rtl/act_writeback.sv - requantizes activated values to int8 and packs them four per unified-buffer word
module act_writeback #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 10
) (
    input  logic          clk,
    input  logic          reset,
    act_writeback_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic              take_start;
    logic              accept;
    logic              emit;
    logic              last_val;
    logic              word_full;

    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        shift_q;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       pack_q;
    logic [1:0]        idx_q;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;

    logic signed [32:0] ext;
    logic signed [32:0] rnd;
    logic signed [32:0] sum;
    logic signed [32:0] q;
    logic [7:0]         qbyte;
    logic [31:0]        word;

    assign last_val  = ((cnt_q + CNT_W'(1)) == num_q);
    assign word_full = (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_start = 1'b0;
        accept     = 1'b0;
        emit       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    take_start = 1'b1;
                    state_next = (bus.num_vals == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.valid_in) begin
                    accept = 1'b1;
                    emit   = last_val || word_full;
                    if (last_val) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // 33-bit signed round-half-up then arithmetic shift; the extra bit absorbs the rounding carry.
    always_comb begin
        ext = {bus.data_in[31], bus.data_in};
        rnd = (shift_q == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift_q - 5'd1));
        sum = ext + rnd;
        q   = sum >>> shift_q;
        if (q > 33'sd127) begin
            qbyte = 8'h7f;
        end else if (q < -33'sd128) begin
            qbyte = 8'h80;
        end else begin
            qbyte = q[7:0];
        end
        // Bytes above idx_q in pack_q are always zero, so a partial word comes out zero-padded.
        word = {8'h00, pack_q} | ({24'h000000, qbyte} << {idx_q, 3'b000});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            pack_q    <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (take_start) begin
                num_q   <= bus.num_vals;
                shift_q <= bus.shift;
                addr_q  <= bus.base_addr;
                cnt_q   <= '0;
                idx_q   <= '0;
                pack_q  <= '0;
            end
            if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (emit) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addr_q;
                    wr_data_q <= word;
                    addr_q    <= addr_q + ADDR_W'(1);
                    idx_q     <= '0;
                    pack_q    <= '0;
                end else begin
                    pack_q <= word[23:0];
                    idx_q  <= idx_q + 2'd1;
                end
            end
        end
    end

    assign bus.ub_wr_en   = wr_en_q && !reset;
    assign bus.ub_wr_addr = bus.ub_wr_en ? wr_addr_q : '0;
    assign bus.ub_wr_data = bus.ub_wr_en ? wr_data_q : '0;
    assign bus.busy       = (state == S_RUN) && !reset;
    assign bus.done       = (state == S_DONE) && !reset;
endmodule

// File: tb/tb_act_writeback.sv
// tb/tb_act_writeback.sv - directed and randomized checks of act_writeback against a job-level reference model
module tb_act_writeback;
    logic clk = 1'b0;
    logic reset = 1'b1;

    act_writeback_if #(.ADDR_W(8), .CNT_W(10)) bus ();

    act_writeback #(.ADDR_W(8), .CNT_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Job-level model: 0 idle, 1 collecting values, 2 finishing cycle.
    int         m_phase = 0;
    int         m_n, m_cnt, m_sh, m_word;
    logic [7:0] m_base;
    logic [7:0] m_q[$];

    function automatic logic [7:0] quant(logic [31:0] d, int sh);
        longint v;
        v = longint'($signed(d));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit st, input logic [7:0] ba, input logic [9:0] n,
                        input logic [4:0] sh, input bit vld, input logic [31:0] d);
        logic       e_en, e_done;
        logic [7:0] e_addr;
        logic [31:0] e_data;
        reset         = rst;
        bus.start     = st;
        bus.base_addr = ba;
        bus.num_vals  = n;
        bus.shift     = sh;
        bus.valid_in  = vld;
        bus.data_in   = d;
        @(posedge clk);
        #1;
        e_en = 0; e_done = 0; e_addr = '0; e_data = '0;
        if (rst) begin
            m_phase = 0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: if (st) begin
                    m_n = int'(n); m_sh = int'(sh); m_base = ba;
                    m_cnt = 0; m_word = 0; m_q.delete();
                    if (n == 0) begin m_phase = 2; e_done = 1; end
                    else m_phase = 1;
                end
                1: if (vld) begin
                    m_q.push_back(quant(d, m_sh));
                    m_cnt++;
                    if (m_q.size() == 4 || m_cnt == m_n) begin
                        e_en = 1;
                        e_addr = m_base + 8'(m_word);
                        foreach (m_q[k]) e_data = e_data | (32'(m_q[k]) << (8 * k));
                        m_q.delete();
                        m_word++;
                    end
                    if (m_cnt == m_n) begin m_phase = 2; e_done = 1; end
                end
                default: m_phase = 0;
            endcase
        end
        check("ub_wr_en", 32'(bus.ub_wr_en), 32'(e_en));
        if (e_en) begin
            check("ub_wr_addr", 32'(bus.ub_wr_addr), 32'(e_addr));
            check("ub_wr_data", bus.ub_wr_data, e_data);
        end else if (rst) begin
            check("rst_addr", 32'(bus.ub_wr_addr), 32'd0);
            check("rst_data", bus.ub_wr_data, 32'd0);
        end
        check("done", 32'(bus.done), 32'(e_done));
        check("busy", 32'(bus.busy), 32'(m_phase == 1 && !rst));
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 8'h00, 10'd0, 5'd0, 0, 32'd0);
    endtask

    task automatic val(logic [31:0] d);
        step(0, 0, 8'h00, 10'd0, 5'd0, 1, d);
    endtask

    initial begin
        logic [31:0] ninep [5];
        int guard;
        ninep = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd7};

        // Reset, including start/valid asserted while reset is high.
        step(1, 0, 8'h00, 10'd0, 5'd0, 0, 32'd0);
        step(1, 1, 8'h10, 10'd4, 5'd0, 1, 32'd5);
        step(1, 0, 8'h00, 10'd0, 5'd0, 1, 32'd5);
        idle(2);

        // Full words.
        step(0, 1, 8'h10, 10'd8, 5'd0, 0, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            val(32'(i));
            if (i == 4) check("req031_w0", bus.ub_wr_data, 32'h04030201);
            if (i == 8) begin
                check("req031_w1", bus.ub_wr_data, 32'h08070605);
                check("req031_a1", 32'(bus.ub_wr_addr), 32'h11);
                check("req031_done", 32'(bus.done), 32'd1);
            end
        end
        idle(2);

        // Rounding, saturation and negative rounding.
        step(0, 1, 8'h30, 10'd4, 5'd4, 0, 32'd0);
        val(32'd24); val(32'd23); val(32'd5000); val(32'd0);
        check("req032_word", bus.ub_wr_data, 32'h007F0102);
        idle(1);
        step(0, 1, 8'h31, 10'd1, 5'd1, 0, 32'd0);
        val(32'hFFFF_FFFD);
        check("req032_neg", bus.ub_wr_data, 32'h000000FF);
        idle(1);

        // Partial final word with address wrap.
        step(0, 1, 8'hFF, 10'd5, 5'd0, 0, 32'd0);
        for (int i = 0; i < 5; i++) val(ninep[i]);
        check("req033_data", bus.ub_wr_data, 32'h00000007);
        check("req033_addr", 32'(bus.ub_wr_addr), 32'h00);
        idle(1);

        // Zero-length job, then a start pulsed mid-job.
        step(0, 1, 8'h50, 10'd0, 5'd0, 0, 32'd0);
        idle(2);
        step(0, 1, 8'h60, 10'd3, 5'd0, 0, 32'd0);
        val(32'd1);
        step(0, 1, 8'hA0, 10'd1, 5'd3, 1, 32'd2);
        val(32'd3);
        check("req034_addr", 32'(bus.ub_wr_addr), 32'h60);
        idle(1);

        // Reset mid-job, then a clean job at 0x20.
        step(0, 1, 8'h40, 10'd4, 5'd0, 0, 32'd0);
        val(32'd11); val(32'd12);
        step(1, 0, 8'h00, 10'd0, 5'd0, 1, 32'd13);
        idle(2);
        step(0, 1, 8'h20, 10'd4, 5'd0, 0, 32'd0);
        val(32'd21); val(32'd22); val(32'd23); val(32'd24);
        check("req035_addr", 32'(bus.ub_wr_addr), 32'h20);
        idle(1);

        // Gapped input.
        step(0, 1, 8'h70, 10'd4, 5'd0, 0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(i + 1);
            val(32'(100 + i));
        end
        idle(2);

        // Random jobs with gaps, stray starts and stray valid beats.
        for (int j = 0; j < 40; j++) begin
            step(0, 1, 8'($urandom()), 10'($urandom_range(0, 11)), 5'($urandom_range(0, 31)), 0, 32'd0);
            guard = 0;
            while (m_phase == 1 && guard < 400) begin
                step(0, $urandom_range(0, 9) == 0, 8'($urandom()), 10'($urandom_range(0, 11)),
                     5'($urandom()), $urandom_range(0, 9) < 7,
                     ($urandom_range(0, 3) == 0) ? $urandom() : (32'($urandom_range(0, 2000)) - 32'd1000));
                guard++;
            end
            check("job_bound", 32'(m_phase != 1), 32'd1);
            step(0, $urandom_range(0, 1) == 1, 8'h00, 10'd3, 5'd0, $urandom_range(0, 1) == 1, $urandom());
            if (m_phase == 1) begin
                while (m_phase == 1) val($urandom());
            end
            if ($urandom_range(0, 4) == 0) step(1, 0, 8'h00, 10'd0, 5'd0, 0, 32'd0);
            idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/act_writeback.md
ACT_WRITEBACK -- requirements
Module: act_writeback

Interface
REQ-001 Parameter ADDR_W, default 8, unified-buffer word address width.
REQ-002 Parameter CNT_W, default 10, width of the value-count field.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a writeback job.
REQ-006 base_addr  input  ADDR_W  first word address, sampled on an accepted start.
REQ-007 num_vals  input  CNT_W  number of activated values in the job, sampled on an accepted start.
REQ-008 shift  input  5  requantization right-shift amount, sampled on an accepted start.
REQ-009 valid_in  input  1  data_in is valid this cycle; driven by the activation stage.
REQ-010 data_in  input  32 (signed)  activated value.
REQ-011 ub_wr_en  output  1  unified-buffer write strobe, one cycle per word.
REQ-012 ub_wr_addr  output  ADDR_W  write word address.
REQ-013 ub_wr_data  output  32  four packed int8 values.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse at job end.

Function
REQ-016 The block SHALL implement states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE in the cycle after the num_vals-th accepted value.
- DONE->IDLE after one cycle.
REQ-017 start SHALL be accepted only in IDLE; start in RUN or DONE SHALL be ignored.
REQ-018 If start arrives with num_vals==0, the block SHALL go IDLE->DONE, pulse done once and issue no writes.
REQ-019 valid_in SHALL be ignored outside RUN; beats beyond num_vals SHALL be ignored.
REQ-020 Requantization of an accepted value:
- rounding constant r = 0 if shift==0, else 1<<(shift-1);
- compute q = (data_in + r) >>> shift in 33-bit signed arithmetic, so there is no overflow;
- saturate q to [-128, 127].
REQ-021 Byte packing SHALL be little-endian: the k-th value of a word goes to ub_wr_data[8k+7:8k], k = 0..3.
REQ-022 A word SHALL be written when its 4th byte is accepted, or when the job's last value is accepted.
- In a partial final word, unused bytes SHALL be 0x00.
REQ-023 Write timing:
- ub_wr_en SHALL assert exactly one cycle after the accepting clock edge of the completing value;
- ub_wr_addr and ub_wr_data SHALL be valid only while ub_wr_en=1.
REQ-024 Addressing:
- the first word SHALL use base_addr;
- each following word SHALL use the previous address +1, wrapping modulo 2^ADDR_W.
REQ-025 done SHALL assert in the same cycle as the final ub_wr_en (or per REQ-018), and busy SHALL deassert in that cycle.
REQ-026 The block SHALL accept one value per cycle with no backpressure; back-to-back valid_in SHALL lose no data.
REQ-027 Gaps in valid_in SHALL NOT alter packing, addressing or the value count.

Reset
REQ-028 While reset=1, the state SHALL be IDLE and ub_wr_en, ub_wr_addr, ub_wr_data, busy and done SHALL all be 0.
REQ-029 Reset mid-job SHALL discard any partial word and the count, with no write issued.
- The next job SHALL behave as if from power-up.
REQ-030 Reset SHALL take priority over start and valid_in in the same cycle.

Verification
REQ-031 Full words: start with base_addr=0x10, num_vals=8, shift=0; inputs 1,2,3,4,5,6,7,8 on consecutive cycles -> writes 0x04030201 @0x10 and 0x08070605 @0x11; done coincides with the second write.
REQ-032 Rounding and saturation: shift=4; inputs 24, 23, 5000, 0 -> bytes 0x02, 0x01, 0x7F, 0x00 -> write 0x007F0102.
- Negative input: shift=1, value -3 -> -1 (0xFF).
REQ-033 Partial word and wrap: base_addr=0xFF, num_vals=5, shift=0; inputs 9,9,9,9,7 -> writes 0x09090909 @0xFF and 0x00000007 @0x00.
REQ-034 Zero-length job and ignored start:
- num_vals=0 -> done pulse, no ub_wr_en;
- a start pulsed during RUN -> no change to address or count.
REQ-035 Reset mid-job: reset after 2 of 4 values -> no write, outputs 0.
- A new 4-value job from base_addr=0x20 then writes correctly to 0x20.
REQ-036 Gapped input: 4 values with idle cycles between them -> one correct write, one cycle after the 4th value.
